// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   - mrs_state_e     : responder FSM state encoding
//   - MRS_DEFAULT_*   : default DEPTH / LATENCY
//   - sat_inc16       : saturating 16-bit increment used by the statistics counters
// The statistics feature is selected with the MEM_RESP_STATS_EN macro, defined
// project-wide on the tool command line when wanted.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MRS_IDLE = 2'b00,
    MRS_BUSY = 2'b01,
    MRS_RESP = 2'b10
  } mrs_state_e;

  localparam int unsigned MRS_DEFAULT_DEPTH   = 256;
  localparam int unsigned MRS_DEFAULT_LATENCY = 3;
  localparam logic [15:0] MRS_COUNT_MAX       = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == MRS_COUNT_MAX) ? value : (value + 16'd1);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word array with registered read.
// Ports:
//   clock  - rising-edge clock
//   reset  - async active-high reset (read register only; contents not reset)
//   we     - write enable: mem[idx] <= wdata
//   re     - read enable: rdata <= mem[idx]; rdata holds otherwise
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data
module data_mem_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Next read register value: load on read enable, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[idx];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage write port; contents intentionally have no reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read data register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage memory interface. Accepts a held load/store
// request in IDLE, waits LATENCY cycles, performs the access on the edge that
// enters RESP and pulses resp_valid for one cycle. mem_stall holds the
// pipeline while a request is outstanding.
// Ports:
//   clock, reset            - clock, async active-high reset
//   mem_read, mem_write     - request (held until resp_valid); both high = store
//   addr, wdata             - byte address (word index addr[log2(DEPTH)+1:2]), store data
//   rdata                   - load data, held until the next load completes
//   resp_valid              - one-cycle completion pulse
//   mem_stall               - combinational stall
//   err_both, err_misalign  - sticky error flags, set at acceptance
//   rd_count, wr_count      - completion counters (MEM_RESP_STATS_EN), else 0
// Optional feature macro: MEM_RESP_STATS_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = MRS_DEFAULT_DEPTH,
  parameter int unsigned LATENCY = MRS_DEFAULT_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        mem_stall,
  output logic        err_both,
  output logic        err_misalign,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  mrs_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_both_q, err_both_d;
  logic             err_mis_q, err_mis_d;
  logic             req_s;
  logic             enter_resp_s;
  logic             mem_we_s;
  logic             mem_re_s;
  logic             unused_addr_s;

  assign req_s = mem_read | mem_write;
  // Address bits above the word index are ignored, which gives modulo-DEPTH wrap.
  assign unused_addr_s = ^addr[31:IDX_W+2];

  // FSM next state, request latch, latency counter and sticky error flags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_wr_d      = op_wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    err_both_d   = err_both_q;
    err_mis_d    = err_mis_q;
    enter_resp_s = 1'b0;
    case (state_q)
      MRS_IDLE: begin
        if (req_s) begin
          // A simultaneous read+write is served as a store.
          op_wr_d    = mem_write;
          idx_d      = addr[IDX_W+1:2];
          wdata_d    = wdata;
          err_both_d = err_both_q | (mem_read & mem_write);
          err_mis_d  = err_mis_q | (addr[1:0] != 2'b00);
          if (LATENCY == 1) begin
            state_d      = MRS_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = MRS_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = MRS_IDLE;
        end
      end
      MRS_BUSY: begin
        if (cnt_q == '0) begin
          state_d      = MRS_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MRS_RESP: begin
        state_d = MRS_IDLE;
      end
      default: begin
        state_d = MRS_IDLE;
      end
    endcase
  end

  // *_d already carries the freshly accepted request when LATENCY=1 (IDLE->RESP),
  // and the latched one otherwise, so the array always sees the right operands.
  // Reset gating keeps a held request from writing while in reset.
  assign mem_we_s = enter_resp_s & op_wr_d & ~reset;
  assign mem_re_s = enter_resp_s & ~op_wr_d;

  // FSM and request latch registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= MRS_IDLE;
      cnt_q      <= '0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0000_0000;
      err_both_q <= 1'b0;
      err_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_both_q <= err_both_d;
      err_mis_q  <= err_mis_d;
    end
  end

  data_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .idx   (idx_d),
    .wdata (wdata_d),
    .rdata (rdata)
  );

  assign resp_valid   = (state_q == MRS_RESP);
  assign mem_stall    = req_s & ~resp_valid;
  assign err_both     = err_both_q;
  assign err_misalign = err_mis_q;

`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Completion counters advance once per RESP cycle, saturating.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == MRS_RESP) begin
      if (op_wr_q) begin
        wr_count_d = sat_inc16(wr_count_q);
      end else begin
        rd_count_d = sat_inc16(rd_count_q);
      end
    end else begin
      rd_count_d = rd_count_q;
    end
  end

  // Completion counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count_q <= 16'h0000;
      wr_count_q <= 16'h0000;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized loads/stores,
// compared against a word-array reference model kept in the bench.
module tb_data_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, mem_stall, err_both, err_misalign;
  logic [15:0] rd_count, wr_count;

  logic        mem_read1, mem_write1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        resp_valid1, mem_stall1, err_both1, err_misalign1;
  logic [15:0] rd_count1, wr_count1;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_ok  [DEPTH];
  logic [31:0] exp_rdata;
  bit          exp_rdata_ok;
  bit          exp_eb, exp_em;
  int          exp_rd, exp_wr;

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .resp_valid(resp_valid),
    .mem_stall(mem_stall), .err_both(err_both), .err_misalign(err_misalign),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  data_mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mem_read(mem_read1), .mem_write(mem_write1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .resp_valid(resp_valid1),
    .mem_stall(mem_stall1), .err_both(err_both1), .err_misalign(err_misalign1),
    .rd_count(rd_count1), .wr_count(wr_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  task automatic check_counts(input string tag, input int erd, input int ewr,
                              input logic [15:0] grd, input logic [15:0] gwr);
`ifdef MEM_RESP_STATS_EN
    check({tag, "_rd_count"}, {16'h0000, grd}, erd);
    check({tag, "_wr_count"}, {16'h0000, gwr}, ewr);
`else
    check({tag, "_rd_count"}, {16'h0000, grd}, 32'd0);
    check({tag, "_wr_count"}, {16'h0000, gwr}, 32'd0);
    if (erd < 0 || ewr < 0) $display("note: negative expected count");
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check("idle_resp", resp_valid, 1'b0);
      check("idle_stall", mem_stall, 1'b0);
    end
    check_counts("idle", exp_rd, exp_wr, rd_count, wr_count);
  endtask

  // One request held from its first cycle until resp_valid; optionally scrambles
  // addr/wdata after acceptance, which must be ignored.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    int k;
    bit seen;
    int i;
    @(negedge clock);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    check("stall_req", mem_stall, 1'b1);
    check("resp_early", resp_valid, 1'b0);
    seen = 0;
    k = 0;
    while (!seen && k < LAT + 5) begin
      @(negedge clock);
      k++;
      if (scramble) begin
        addr = $urandom; wdata = $urandom;
      end
      #1;
      if (resp_valid) seen = 1;
      else check("stall_busy", mem_stall, 1'b1);
    end
    check("latency", k, LAT);
    i = widx(a);
    exp_eb = exp_eb | (rd & wr);
    exp_em = exp_em | (a[1:0] != 2'b00);
    if (wr) begin
      model_mem[i] = d;
      model_ok[i]  = 1;
      exp_wr++;
    end else begin
      exp_rdata    = model_mem[i];
      exp_rdata_ok = model_ok[i];
      exp_rd++;
    end
    check("stall_resp", mem_stall, 1'b0);
    if (exp_rdata_ok) check(wr ? "rdata_hold" : "rdata_load", rdata, exp_rdata);
    check("err_both", err_both, exp_eb);
    check("err_misalign", err_misalign, exp_em);
  endtask

  task automatic model_reset();
    exp_eb = 0; exp_em = 0; exp_rd = 0; exp_wr = 0;
    exp_rdata = 32'h0000_0000; exp_rdata_ok = 1;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0000_0000;
      model_ok[i]  = 0;
    end
    model_reset();
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    mem_read1 = 1'b0; mem_write1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", resp_valid, 1'b0);
    check("rst_err_both", err_both, 1'b0);
    check("rst_err_mis", err_misalign, 1'b0);
    check_counts("rst", 0, 0, rd_count, wr_count);
    check("rst_rdata1", rdata1, 32'h0);
    reset = 1'b0;
    idle(2);

    // Store then back-to-back load.
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    idle(1);

    // Latched operands: later addr/wdata changes are ignored.
    do_txn(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
    do_txn(1'b0, 1'b1, 32'h4, 32'h12345678, 1'b1);
    do_txn(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    do_txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // Address wrap: 0x400 aliases word 0.
    do_txn(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
    do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Randomized aligned single-op traffic.
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      if ($urandom_range(0, 1) == 1) do_txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, 1) == 1);
      else                           do_txn(1'b0, 1'b1, a, $urandom, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Both ops + misaligned: store lands in word 8, flags become sticky.
    do_txn(1'b1, 1'b1, 32'h22, 32'h0BADF00D, 1'b0);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0);
    idle(2);
    check("sticky_both", err_both, 1'b1);
    check("sticky_mis", err_misalign, 1'b1);

    // Reset in BUSY of a store to 0x20: discarded, no response.
    @(negedge clock);
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h20; wdata = 32'h99999999;
    @(negedge clock);
    reset = 1'b1; mem_write = 1'b0;
    #1;
    check("rst_mid_resp", resp_valid, 1'b0);
    check("rst_mid_both", err_both, 1'b0);
    check("rst_mid_mis", err_misalign, 1'b0);
    check("rst_mid_rdata", rdata, 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle(4);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h3C, 32'h3C3C3C3C, 1'b0);
    do_txn(1'b1, 1'b0, 32'h3C, 32'h0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h40, 32'h40404040, 1'b0);
    idle(2);
    check_counts("stats", 3, 2, rd_count, wr_count);

    // LATENCY=1 instance: store, then a continuously held load.
    @(negedge clock);
    mem_write1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h5A5A0001;
    #1;
    check("l1_stall_st", mem_stall1, 1'b1);
    check("l1_resp_st0", resp_valid1, 1'b0);
    @(negedge clock);
    #1;
    check("l1_resp_st1", resp_valid1, 1'b1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      mem_write1 = 1'b0; mem_read1 = 1'b1;
      #1;
      check("l1_resp", resp_valid1, (j % 2) == 1);
      check("l1_stall", mem_stall1, (j % 2) == 0);
      if (j % 2 == 1) check("l1_rdata", rdata1, 32'h5A5A0001);
    end
    @(negedge clock);
    mem_read1 = 1'b0;
    @(negedge clock);
    #1;
    check("l1_resp_off", resp_valid1, 1'b0);
    check("l1_err", {err_both1, err_misalign1}, 2'b00);
    check_counts("l1", 4, 1, rd_count1, wr_count1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage memory interface.
- Consumes the MemRead/MemWrite/address/write-data request that the main control drives into the MEM stage.
- Serves each request from an internal word array with a fixed multi-cycle latency.
- Returns a one-cycle response pulse, and holds a combinational stall that freezes the pipeline until the response arrives.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 2.
- LATENCY, 3, cycles from request acceptance to response; at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request; held by initiator until resp_valid.
- mem_write  in  1  store request; held by initiator until resp_valid.
- addr  in  32  byte address; word index = addr[log2(DEPTH)+1:2].
- wdata  in  32  store data.
- rdata  out  32  load data, registered, valid while resp_valid=1 and held until the next load completes.
- resp_valid  out  1  one-cycle completion pulse.
- mem_stall  out  1  combinational: (mem_read|mem_write) & ~resp_valid.
- err_both  out  1  sticky: mem_read and mem_write were both high at an acceptance.
- err_misalign  out  1  sticky: addr[1:0]!=0 at an acceptance.
- rd_count  out  16  load completions (see Optional Feature).
- wr_count  out  16  store completions (see Optional Feature).

Behaviour:
- Reset values: state IDLE; rdata=0; resp_valid=0; err_both=0; err_misalign=0; rd_count=0; wr_count=0. Array contents are not reset.
- States:
  - IDLE: accepting.
  - BUSY: counting down.
  - RESP: one cycle, resp_valid=1.
- Acceptance: in IDLE with mem_read|mem_write=1, latch op, word index and wdata at that edge.
- Transitions:
  - IDLE → BUSY when LATENCY≥2; IDLE → RESP directly when LATENCY=1.
  - BUSY counter loads LATENCY-2 and decrements; BUSY → RESP when the counter reaches 0.
  - RESP → IDLE unconditionally.
- Latency: a request first present in cycle N sees resp_valid=1 in cycle N+LATENCY.
- Access timing: the array write and the rdata load occur on the edge entering RESP. Only latched values are used; input changes after acceptance are ignored.
- Pipeline advance: mem_stall drops in the RESP cycle, so the pipeline advances on that edge.
- Back-to-back requests: a request still present in the cycle after RESP (IDLE) is a new request. Minimum spacing is LATENCY+1 cycles per access.
- Both mem_read and mem_write high: treated as a store; err_both sets.
- Misaligned address: access uses the truncated word index; err_misalign sets.
- Address beyond DEPTH: wraps modulo DEPTH (upper bits ignored).
- A load completion updates rdata; a store completion leaves rdata unchanged.
- Reset mid-operation: return to IDLE immediately; a pending store is discarded (array untouched); no resp_valid is generated.
- mem_stall during reset: follows the request inputs. The initiator is itself in reset, so this is harmless.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- Defined: rd_count/wr_count increment by 1 in each RESP cycle for a load or store respectively, saturating at 16'hFFFF, cleared by reset.
- Undefined: no counter registers; both ports tied to 0.

Decomposition:
- constants.h holds:
  - state encodings MRS_IDLE=2'b00, MRS_BUSY=2'b01, MRS_RESP=2'b10;
  - default DEPTH/LATENCY;
  - MEM_RESP_STATS_EN, if enabled project-wide.
- One natural sub-module: data_mem_array, a single-port synchronous array (32-bit, DEPTH words, one write enable, registered read). The FSM, counter, error flags and stats stay in data_mem_responder.

Test Plan:
- LATENCY=3, store addr=0x10 wdata=0xDEADBEEF in cycle 5 → mem_stall=1 in cycles 5–7, resp_valid=1 only in cycle 8; then a load from 0x10 in cycle 9 → rdata=0xDEADBEEF with resp_valid in cycle 12.
- LATENCY=1, load held continuously from addr 0x0 → resp_valid every 2nd cycle; mem_stall alternates 1/0.
- Store 0x12345678 to addr 0x4 in cycle 0, change addr to 0x8 and wdata to 0 in cycle 1 → word 1 = 0x12345678 and word 2 unchanged (latched values used).
- mem_read=mem_write=1, addr=0x22 → err_both=1, err_misalign=1, store lands in word 8; both flags stay 1 until reset.
- DEPTH=256, store to addr 0x400 → aliases word 0; a load from 0x0 returns the stored data.
- Assert reset in BUSY of a store to 0x20 → state IDLE, no resp_valid, word 8 unchanged. With MEM_RESP_STATS_EN, 3 loads + 2 stores → rd_count=3, wr_count=2.
